posit_norm_adjust_p: RTL and testbench

- Parametrised normaliser for the posit multiply path.
- Takes the raw mantissa product and the combined scale. Shifts the mantissa until its leading one sits at bit MANT_W-2, and corrects the scale to match.
- Splits the corrected scale into sign, regime and exponent fields for the posit encoder.
- Generalises the fixed 64-bit single-step adjuster: configurable widths, multi-bit shift steps, sticky tracking, zero/saturation flags and a busy/done handshake.

---
 rtl/posit_norm_adjust_p.sv | 118 +++++++++++
 tb/tb_posit_norm_adjust_p.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/posit_norm_adjust_p.sv
// posit_norm_adjust_p: normalises a posit mantissa product and applies the matching saturating scale correction.
// Define NORM_LZC_EN to do the whole left shift in one cycle with a leading-zero count instead of STEP/1 steps.
module posit_norm_adjust_p #(
  parameter int MANT_W = 64,
  parameter int SCALE_W = 10,
  parameter int ES = 3,
  parameter int STEP = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SCALE_W-1:0]        scale_in,
  input  logic [MANT_W-1:0]         mant_in,
  output logic                      busy,
  output logic                      done,
  output logic [MANT_W-1:0]         mant_adj,
  output logic [SCALE_W-1:0]        scale_out,
  output logic [$clog2(MANT_W):0]   shift_amt,
  output logic                      sticky,
  output logic                      rshift,
  output logic                      zero,
  output logic                      sat,
  output logic [ES-1:0]             adj_exp,
  output logic [SCALE_W-ES-2:0]     adj_regime,
  output logic                      exp_sign
);
  localparam int SHW = $clog2(MANT_W) + 1;
  localparam int WW = SCALE_W + SHW + 1;
  localparam logic signed [WW-1:0] SMAX = WW'((1 << (SCALE_W - 1)) - 1);
  localparam logic signed [WW-1:0] SMIN = ~SMAX;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [MANT_W-1:0] work, work_n;
  logic [SHW-1:0] lsh;
  logic signed [WW-1:0] delta, wide;
  logic signed [SCALE_W-1:0] scale_s;
  logic [SCALE_W-1:0] scale_n;
  logic ovf;
`ifdef NORM_LZC_EN
  logic [SHW-1:0] lz;
  // Highest set bit below the overflow position wins, giving its distance to MANT_W-2.
  always_comb begin
    lz = '0;
    for (int i = 0; i < MANT_W - 1; i++) if (work[i]) lz = SHW'(MANT_W - 2 - i);
  end
`endif
  always_comb begin
    state_n = state;
    work_n = work;
    delta = '0;
    lsh = '0;
    case (state)
      IDLE: state_n = start ? SHIFT : IDLE;
      SHIFT:
        if (work == '0 || work[MANT_W-1] || work[MANT_W-2]) begin
          state_n = DONE;
          work_n = work[MANT_W-1] ? work >> 1 : work;
          delta = work[MANT_W-1] ? WW'(1) : '0;
        end else begin
`ifdef NORM_LZC_EN
          lsh = lz;
          state_n = DONE;
`else
          lsh = (work[MANT_W-2 -: STEP] == '0) ? SHW'(STEP) : SHW'(1);
`endif
          work_n = work << lsh;
          delta = -WW'(lsh);
        end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign scale_s = signed'(scale_out);
  assign wide = WW'(scale_s) + delta;
  assign ovf = wide > SMAX || wide < SMIN;
  assign scale_n = wide > SMAX ? SMAX[SCALE_W-1:0] : wide < SMIN ? SMIN[SCALE_W-1:0] : wide[SCALE_W-1:0];
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      work <= '0;
      mant_adj <= '0;
      scale_out <= '0;
      shift_amt <= '0;
      sticky <= 1'b0;
      rshift <= 1'b0;
      zero <= 1'b0;
      sat <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        work <= mant_in;
        scale_out <= scale_in;
        shift_amt <= '0;
        sticky <= 1'b0;
        rshift <= 1'b0;
        zero <= 1'b0;
        sat <= 1'b0;
      end else if (state == SHIFT) begin
        work <= work_n;
        scale_out <= scale_n;
        shift_amt <= shift_amt + lsh;
        sat <= sat | ovf;
        zero <= work == '0;
        if (work[MANT_W-1]) begin
          sticky <= work[0];
          rshift <= 1'b1;
        end
        // Publish the result as DONE is entered so it is valid alongside the done pulse.
        if (state_n == DONE) mant_adj <= work_n;
      end
    end
  end
  assign busy = state == SHIFT;
  assign done = state == DONE;
  assign adj_exp = scale_out[ES-1:0];
  assign adj_regime = scale_out[SCALE_W-2:ES];
  assign exp_sign = scale_out[SCALE_W-1];
endmodule

// File: tb/tb_posit_norm_adjust_p.sv
// tb_posit_norm_adjust_p: scoreboard bench for posit_norm_adjust_p with an arithmetic reference model.
module tb_posit_norm_adjust_p;
  logic clk = 0, reset = 0, start = 0;
  logic [9:0] scale_in = '0;
  logic [63:0] mant_in = '0;
  logic busy, done, sticky, rshift, zero, sat, exp_sign;
  logic [63:0] mant_adj;
  logic [9:0] scale_out;
  logic [6:0] shift_amt;
  logic [2:0] adj_exp;
  logic [5:0] adj_regime;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [63:0] mant;
    int scale, sh, lat, c0;
    bit sticky, rshift, zero, sat;
  } exp_t;
  exp_t q[$];

  posit_norm_adjust_p dut (
    .clk(clk), .reset(reset), .start(start), .scale_in(scale_in), .mant_in(mant_in),
    .busy(busy), .done(done), .mant_adj(mant_adj), .scale_out(scale_out), .shift_amt(shift_amt),
    .sticky(sticky), .rshift(rshift), .zero(zero), .sat(sat), .adj_exp(adj_exp),
    .adj_regime(adj_regime), .exp_sign(exp_sign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  // Reference: find the leading one, shift it to bit 62 in one go, clamp the scale once.
  function automatic exp_t model(input logic [63:0] m, input logic [9:0] s);
    exp_t e;
    int p = -1;
    int sc = int'($signed(s));
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    e.mant = m; e.sh = 0; e.lat = 2; e.c0 = 0;
    e.sticky = 0; e.rshift = 0; e.zero = 0;
    if (p < 0) e.zero = 1;
    else if (p == 63) begin
      e.mant = m >> 1; e.sticky = m[0]; e.rshift = 1; sc = sc + 1;
    end else begin
      e.sh = 62 - p; e.mant = m << (62 - p); sc = sc - (62 - p);
`ifndef NORM_LZC_EN
      for (int k = p; k < 62; k += (k < 59) ? 4 : 1) e.lat++;
`endif
    end
    e.sat = sc > 511 || sc < -512;
    e.scale = sc > 511 ? 511 : sc < -512 ? -512 : sc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        int su;
        e = q.pop_front();
        su = e.scale & 1023;
        chk("mant_adj", mant_adj, e.mant);
        chk("scale_out", 64'(scale_out), 64'(su));
        chk("shift_amt", 64'(shift_amt), 64'(e.sh));
        chk("sticky", 64'(sticky), 64'(e.sticky));
        chk("rshift", 64'(rshift), 64'(e.rshift));
        chk("zero", 64'(zero), 64'(e.zero));
        chk("sat", 64'(sat), 64'(e.sat));
        chk("adj_exp", 64'(adj_exp), 64'(su % 8));
        chk("adj_regime", 64'(adj_regime), 64'((su / 8) % 64));
        chk("exp_sign", 64'(exp_sign), 64'(su / 512));
        chk("latency", 64'(cyc - e.c0 + 1), 64'(e.lat));
      end
    end
  end

  // Called at a negedge; waits for IDLE, issues a start and records the cycle of the accepting edge.
  task automatic issue(input logic [63:0] m, input logic [9:0] s, input bit track, input bit junk);
    exp_t e;
    for (int t = 0; t < 100 && (busy || done); t++) @(negedge clk);
    mant_in = m; scale_in = s; start = 1;
    e = model(m, s);
    @(posedge clk); #1;
    e.c0 = cyc;
    if (track) q.push_back(e);
    if (junk) begin
      mant_in = {$urandom, $urandom}; scale_in = 10'($urandom);
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() > 0; t++) @(posedge clk);
    if (q.size() > 0) begin
      chk("done_timeout", 64'(q.size()), 0);
      q.delete();
    end
  endtask

  task automatic run(input logic [63:0] m, input logic [9:0] s, input bit junk);
    @(negedge clk);
    issue(m, s, 1, junk);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {mant_adj, scale_out, shift_amt, sticky, rshift, zero, sat, busy, done}, 0);
    reset = 1;
    run(64'h4000000000000000, 10'd5, 0);
    run(64'hC000000000000001, 10'd3, 0);
    run(64'h0000000000000001, 10'd100, 0);
    run(64'h0, 10'd7, 0);
    run(64'h2000000000000000, 10'h200, 0);
    run(64'h8000000000000000, 10'd511, 0);
    run(64'h0000000000000001, 10'h1F0, 1);
    @(negedge clk);
    issue(64'h0000000000000001, 10'd100, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("midop_reset_outputs", {mant_adj, scale_out, shift_amt, sticky, rshift, zero, sat, busy, done}, 0);
    reset = 1;
    issue(64'h0000000000000001, 10'd100, 1, 0);
    drain();
    for (int i = 0; i < 60; i++) begin
      logic [63:0] m;
      logic [9:0] s;
      int r = $urandom_range(0, 9);
      m = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (r == 0) m = '0;
      if (r == 1) m[63] = 1;
      s = 10'($urandom);
      if (r == 2) s = 10'h200 + 10'($urandom_range(0, 8));
      if (r == 3) s = 10'h1FF;
      run(m, s, bit'($urandom_range(0, 1)));
    end
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
